// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage sequencer.
//   LOG2N_DEF / PIPE_LAT_DEF : default point-count exponent and butterfly latency
//   N_DEF / HALF_N_DEF       : default point count and butterflies per stage
//   state_e                  : sequencer FSM states
package fft_pkg;

  localparam int unsigned LOG2N_DEF    = 4;
  localparam int unsigned PIPE_LAT_DEF = 2;
  localparam int unsigned N_DEF        = 1 << LOG2N_DEF;
  localparam int unsigned HALF_N_DEF   = N_DEF / 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/fft_addr_gen.sv
// Radix-2 in-place butterfly address generator (purely combinational).
//   i_s  : stage index s
//   i_k  : butterfly index k within the stage
//   o_a  : top operand address  ((k>>s)<<(s+1)) | (k & (2^s-1))
//   o_b  : bottom operand address  a | (1<<s)
//   o_tw : twiddle ROM index  (k & (2^s-1)) << (LOG2N-1-s)
module fft_addr_gen #(
  parameter int unsigned LOG2N = 4
) (
  input  logic [LOG2N-1:0] i_s,
  input  logic [LOG2N-2:0] i_k,
  output logic [LOG2N-1:0] o_a,
  output logic [LOG2N-1:0] o_b,
  output logic [LOG2N-2:0] o_tw
);

  localparam int unsigned     TW_W = LOG2N - 1;
  localparam logic [LOG2N-1:0] ONE = LOG2N'(1);

  logic [LOG2N-1:0] k_ext;
  logic [LOG2N-1:0] mask;
  logic [LOG2N-1:0] low;
  logic [LOG2N-1:0] tw_sh;

  always_comb begin
    k_ext = {1'b0, i_k};
    mask  = (ONE << i_s) - ONE;
    low   = k_ext & mask;
    o_a   = ((k_ext >> i_s) << (i_s + ONE)) | low;
    o_b   = o_a | (ONE << i_s);
    tw_sh = LOG2N'(LOG2N - 1) - i_s;
    // low < 2^s, so the shifted value always fits in LOG2N-1 bits
    o_tw  = TW_W'(low << tw_sh);
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Control sequencer for an N-point in-place radix-2 FFT.
// Issues N/2 operand-pair reads per stage, waits PIPE_LAT cycles for the
// butterfly pipeline to drain, and replays each read pair as a write pair
// exactly PIPE_LAT cycles later.
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_start                  : start request, accepted only in IDLE
//   o_busy, o_done           : high in RUN/DRAIN; one-cycle completion pulse
//   o_rd_en, o_rd_addr_a/b   : operand pair read strobe and addresses
//   o_tw_addr                : twiddle ROM index for the current read
//   o_wr_en, o_wr_addr_a/b   : result pair write strobe and addresses
//   o_stage                  : current stage (0 outside RUN/DRAIN)
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N    = LOG2N_DEF,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_rd_en,
  output logic [LOG2N-1:0] o_rd_addr_a,
  output logic [LOG2N-1:0] o_rd_addr_b,
  output logic [LOG2N-2:0] o_tw_addr,
  output logic             o_wr_en,
  output logic [LOG2N-1:0] o_wr_addr_a,
  output logic [LOG2N-1:0] o_wr_addr_b,
  output logic [LOG2N-1:0] o_stage
);

  localparam logic [LOG2N-1:0] S_LAST     = LOG2N'(LOG2N - 1);
  localparam logic [3:0]       DRAIN_LAST = 4'(PIPE_LAT - 1);

  state_e           state_q, state_d;
  logic [LOG2N-1:0] s_q, s_d;
  logic [LOG2N-2:0] k_q, k_d;
  logic [3:0]       cnt_q, cnt_d;

  logic [PIPE_LAT-1:0]            dly_en_q, dly_en_d;
  logic [PIPE_LAT-1:0][LOG2N-1:0] dly_a_q, dly_a_d;
  logic [PIPE_LAT-1:0][LOG2N-1:0] dly_b_q, dly_b_d;

  logic [LOG2N-1:0] gen_a, gen_b;
  logic [LOG2N-2:0] gen_tw;

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .i_s  (s_q),
    .i_k  (k_q),
    .o_a  (gen_a),
    .o_b  (gen_b),
    .o_tw (gen_tw)
  );

  // State and counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
          s_d     = '0;
          k_d     = '0;
        end
      end
      ST_RUN: begin
        k_d = k_q + 1'b1;
        if (k_q == '1) begin
          state_d = ST_DRAIN;
          k_d     = '0;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == DRAIN_LAST) begin
          if (s_q == S_LAST) begin
            state_d = ST_DONE;
            s_d     = '0;
          end else begin
            state_d = ST_RUN;
            s_d     = s_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_rd_en     = 1'b0;
    o_rd_addr_a = '0;
    o_rd_addr_b = '0;
    o_tw_addr   = '0;
    o_stage     = '0;
    unique case (state_q)
      ST_RUN: begin
        o_busy      = 1'b1;
        o_rd_en     = 1'b1;
        o_rd_addr_a = gen_a;
        o_rd_addr_b = gen_b;
        o_tw_addr   = gen_tw;
        o_stage     = s_q;
      end
      ST_DRAIN: begin
        o_busy  = 1'b1;
        o_stage = s_q;
      end
      ST_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  // Write-back delay line: slot 0 captures this cycle's read
  always_comb begin
    dly_en_d    = dly_en_q;
    dly_a_d     = dly_a_q;
    dly_b_d     = dly_b_q;
    dly_en_d[0] = o_rd_en;
    dly_a_d[0]  = o_rd_addr_a;
    dly_b_d[0]  = o_rd_addr_b;
    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
      dly_en_d[i] = dly_en_q[i-1];
      dly_a_d[i]  = dly_a_q[i-1];
      dly_b_d[i]  = dly_b_q[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dly_en_q <= '0;
      dly_a_q  <= '0;
      dly_b_q  <= '0;
    end else begin
      dly_en_q <= dly_en_d;
      dly_a_q  <= dly_a_d;
      dly_b_q  <= dly_b_d;
    end
  end

  assign o_wr_en     = dly_en_q[PIPE_LAT-1];
  assign o_wr_addr_a = dly_a_q[PIPE_LAT-1];
  assign o_wr_addr_b = dly_b_q[PIPE_LAT-1];

endmodule
